// File: rtl/led_share_sched.sv
// Round-robin time-sharing of the four user LEDs between four status requesters,
// with a blank gap between owners and a tick-counter heartbeat when nobody asks.
module led_share_sched #(
    parameter int DIV   = 12000000,
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] pattern,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic [3:0]  leds
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    idle_cnt_q, idle_cnt_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    owner_q, owner_d;
    logic [3:0]    grant_q, grant_d;
    logic [3:0]    done_q, done_d;
    logic [3:0]    leds_q, leds_d;
    logic          busy_q, busy_d;

    logic          tick;
    logic          win_found;
    logic [1:0]    win_idx;
    logic [1:0]    cand;
    logic          issue;
    logic [3:0]    nib [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign nib[gi] = pattern[4*gi +: 4];
    end

    assign tick    = (presc_q == PW'(DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // Search starts just after the last winner and ends on it, so a lone requester is re-granted.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        idle_cnt_d = idle_cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        done_d     = '0;
        leds_d     = leds_q;
        busy_d     = busy_q;
        issue      = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) idle_cnt_d = idle_cnt_q + 4'd1;
                leds_d  = idle_cnt_d;
                grant_d = '0;
                busy_d  = 1'b0;
                issue   = win_found;
            end
            GRANT: begin
                leds_d = nib[owner_q];
                // Expiry is checked first so a simultaneous req drop still reports done.
                if (tick && (dwell_q == DW'(DWELL - 1))) begin
                    done_d[owner_q] = 1'b1;
                    grant_d         = '0;
                    leds_d          = '0;
                    state_d         = GAP;
                end else if (!req[owner_q]) begin
                    grant_d = '0;
                    leds_d  = '0;
                    state_d = GAP;
                end else if (tick) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            GAP: begin
                leds_d = '0;
                busy_d = 1'b1;
                if (tick) begin
                    if (win_found) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        leds_d  = idle_cnt_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            state_d = GRANT;
            grant_d = 4'b0001 << win_idx;
            owner_d = win_idx;
            last_d  = win_idx;
            busy_d  = 1'b1;
            dwell_d = '0;
            leds_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            dwell_q    <= '0;
            idle_cnt_q <= '0;
            last_q     <= 2'd3;
            owner_q    <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            leds_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            dwell_q    <= dwell_d;
            idle_cnt_q <= idle_cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            leds_q     <= leds_d;
            busy_q     <= busy_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign leds  = leds_q;
endmodule

// File: tb/tb_led_share_sched.sv
// Scoreboard bench: expected output changes (value + clock edge since reset release)
// are queued by the stimulus and matched by an independent monitor.
module tb_led_share_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] pattern = '0;
    logic [3:0]  grant, done, leds;
    logic        busy;

    led_share_sched #(.DIV(4), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .req(req), .pattern(pattern),
        .grant(grant), .done(done), .busy(busy), .leds(leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [3:0] d;
        logic [3:0] l;
        logic       b;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    int   now  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every change of the output bundle is one transaction.
    initial begin
        logic [12:0] prev, cur;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {grant, done, leds, busy};
            if (rst) begin
                prev = cur;
            end else if (cur != prev) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_event edge=%0d g=%b d=%b l=%h b=%b", cyc, grant, done, leds, busy);
                end else begin
                    e = exp_q.pop_front();
                    if (e.g !== grant || e.d !== done || e.l !== leds || e.b !== busy || e.t != cyc) begin
                        errs++;
                        $display("FAIL event got edge=%0d g=%b d=%b l=%h b=%b expected edge=%0d g=%b d=%b l=%h b=%b",
                                 cyc, grant, done, leds, busy, e.t, e.g, e.d, e.l, e.b);
                    end else begin
                        $display("ok edge=%0d g=%b d=%b l=%h b=%b", cyc, grant, done, leds, busy);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic ex(input logic [3:0] g, input logic [3:0] d, input logic [3:0] l, input logic b, input int t);
        exp_t e;
        e.g = g; e.d = d; e.l = l; e.b = b; e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int n);
        repeat (n - now) @(posedge clk);
        #1;
        now = n;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        now = 0;
    endtask

    task automatic end_phase(input string name, input int n);
        goto(n);
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL %s_drain got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            $display("ok %s drained", name);
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s got %b expected %b", name, act, expv);
        end else begin
            $display("ok %s = %b", name, act);
        end
    endtask

    initial begin
        // Heartbeat: ticks land on every 4th edge, leds count up and wrap.
        do_reset();
        for (int m = 1; m <= 16; m++) ex(4'b0000, 4'b0000, 4'(m % 16), 1'b0, 4 * m);
        end_phase("idle", 66);

        // Single requester: slot, gap, re-grant, then drop.
        do_reset();
        pattern = 16'h000A;
        ex(4'b0001, 4'b0000, 4'h0, 1'b1, 2);
        ex(4'b0001, 4'b0000, 4'hA, 1'b1, 3);
        ex(4'b0000, 4'b0001, 4'h0, 1'b1, 8);
        ex(4'b0000, 4'b0000, 4'h0, 1'b1, 9);
        ex(4'b0001, 4'b0000, 4'h0, 1'b1, 12);
        ex(4'b0001, 4'b0000, 4'hA, 1'b1, 13);
        ex(4'b0000, 4'b0000, 4'h0, 1'b1, 15);
        ex(4'b0000, 4'b0000, 4'h0, 1'b0, 16);
        ex(4'b0000, 4'b0000, 4'h1, 1'b0, 20);
        goto(1);
        req = 4'b0001;
        goto(14);
        req = 4'b0000;
        end_phase("single", 22);

        // Round robin over all four, then requester 2 releases early.
        do_reset();
        pattern = 16'h8421;
        ex(4'b0001, 4'b0000, 4'h0, 1'b1, 2);
        ex(4'b0001, 4'b0000, 4'h1, 1'b1, 3);
        ex(4'b0000, 4'b0001, 4'h0, 1'b1, 8);
        ex(4'b0000, 4'b0000, 4'h0, 1'b1, 9);
        for (int s = 0; s < 5; s++) begin
            int o, g0;
            o  = (s + 1) % 4;
            g0 = 12 + 12 * s;
            ex(4'(1 << o), 4'b0000, 4'h0,      1'b1, g0);
            ex(4'(1 << o), 4'b0000, 4'(1 << o), 1'b1, g0 + 1);
            ex(4'b0000,    4'(1 << o), 4'h0,   1'b1, g0 + 8);
            ex(4'b0000,    4'b0000, 4'h0,      1'b1, g0 + 9);
        end
        ex(4'b0100, 4'b0000, 4'h0, 1'b1, 72);
        ex(4'b0100, 4'b0000, 4'h4, 1'b1, 73);
        ex(4'b0000, 4'b0000, 4'h0, 1'b1, 75);
        ex(4'b1000, 4'b0000, 4'h0, 1'b1, 76);
        ex(4'b1000, 4'b0000, 4'h8, 1'b1, 77);
        ex(4'b0000, 4'b1000, 4'h0, 1'b1, 84);
        ex(4'b0000, 4'b0000, 4'h0, 1'b1, 85);
        ex(4'b0001, 4'b0000, 4'h0, 1'b1, 88);
        ex(4'b0001, 4'b0000, 4'h1, 1'b1, 89);
        goto(1);
        req = 4'b1111;
        goto(74);
        req = 4'b1011;
        end_phase("roundrobin", 90);

        // Req drops on the expiring tick: done still pulses; next owner wraps to 0.
        do_reset();
        pattern = 16'h8421;
        ex(4'b0100, 4'b0000, 4'h0, 1'b1, 2);
        ex(4'b0100, 4'b0000, 4'h4, 1'b1, 3);
        ex(4'b0000, 4'b0100, 4'h0, 1'b1, 8);
        ex(4'b0000, 4'b0000, 4'h0, 1'b1, 9);
        ex(4'b0001, 4'b0000, 4'h0, 1'b1, 12);
        ex(4'b0001, 4'b0000, 4'h1, 1'b1, 13);
        ex(4'b0000, 4'b0000, 4'h0, 1'b1, 15);
        ex(4'b0000, 4'b0000, 4'h0, 1'b0, 16);
        goto(1);
        req = 4'b0100;
        goto(7);
        req = 4'b0001;
        goto(14);
        req = 4'b0000;
        end_phase("simul", 18);

        // Asynchronous reset in the middle of a slot.
        do_reset();
        pattern = 16'h8421;
        ex(4'b0010, 4'b0000, 4'h0, 1'b1, 2);
        ex(4'b0010, 4'b0000, 4'h2, 1'b1, 3);
        goto(1);
        req = 4'b0010;
        goto(5);
        #2;
        rst = 1'b1;
        req = 4'b1111;
        #1;
        chk("async_grant", grant, 4'b0000);
        chk("async_leds",  leds,  4'h0);
        chk("async_busy",  {3'b000, busy}, 4'b0000);
        chk("async_done",  done,  4'b0000);
        end_phase("pre_async", 5);
        ex(4'b0001, 4'b0000, 4'h0, 1'b1, 1);
        ex(4'b0001, 4'b0000, 4'h1, 1'b1, 2);
        @(posedge clk); #1;
        rst = 1'b0;
        now = 0;
        end_phase("post_async", 6);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
